// File: rtl/u_idu_iex_pipe_pkg.sv
// Shared widths, ALU control bit positions and the bypass match helper for the ID/EX stage.
package u_idu_iex_pipe_pkg;

    localparam int unsigned PcW    = 32;
    localparam int unsigned DataW  = 32;
    localparam int unsigned CtrlW  = 18;
    localparam int unsigned RfIdxW = 5;

    typedef logic [PcW-1:0]    pc_t;
    typedef logic [DataW-1:0]  data_t;
    typedef logic [CtrlW-1:0]  ctrl_t;
    typedef logic [RfIdxW-1:0] rf_idx_t;

    // Bit positions inside the ALU control bundle; order is fixed by the ALU.
    typedef enum int unsigned {
        CtrlAdderSelSrc1Pc   = 0,
        CtrlAdderSelSrc2Rs2  = 1,
        CtrlGeneralSelSrc2Rs2 = 2,
        CtrlUnsigned         = 3,
        CtrlAdderVld         = 4,
        CtrlAdderSub         = 5,
        CtrlComparatorVld    = 6,
        CtrlAnd              = 7,
        CtrlOr               = 8,
        CtrlXor              = 9,
        CtrlRightShift       = 10,
        CtrlLogicalShift     = 11,
        CtrlJal              = 12,
        CtrlJalr             = 13,
        CtrlBge              = 14,
        CtrlBlt              = 15,
        CtrlBeq              = 16,
        CtrlBne              = 17
    } ctrl_bit_e;

    // x0 is hard-wired, so it never takes a forwarded value.
    function automatic logic fwd_hit(input logic vld, input logic wen,
                                     input rf_idx_t rd_idx, input rf_idx_t src_idx);
        return vld & wen & (rd_idx == src_idx) & (src_idx != '0);
    endfunction

endpackage

// File: rtl/u_idu_iex_pipe_if.sv
// Decoded-instruction bundle from IDU into the ID/EX register, with the back-pressure ready.
interface u_idu_iex_pipe_if;
    import u_idu_iex_pipe_pkg::*;

    logic    idu_iex_vld;
    pc_t     idu_iex_pc;
    rf_idx_t idu_iex_rs1_idx;
    rf_idx_t idu_iex_rs2_idx;
    data_t   idu_iex_rs1_data;
    data_t   idu_iex_rs2_data;
    data_t   idu_iex_imm_data;
    rf_idx_t idu_iex_rd_idx;
    logic    idu_iex_rd_wen;
    logic    idu_iex_is_load;
    ctrl_t   idu_iex_ctrl;
    logic    iex_idu_ready;

    modport master (
        output idu_iex_vld, idu_iex_pc, idu_iex_rs1_idx, idu_iex_rs2_idx, idu_iex_rs1_data,
               idu_iex_rs2_data, idu_iex_imm_data, idu_iex_rd_idx, idu_iex_rd_wen,
               idu_iex_is_load, idu_iex_ctrl,
        input  iex_idu_ready
    );

    modport slave (
        input  idu_iex_vld, idu_iex_pc, idu_iex_rs1_idx, idu_iex_rs2_idx, idu_iex_rs1_data,
               idu_iex_rs2_data, idu_iex_imm_data, idu_iex_rd_idx, idu_iex_rd_wen,
               idu_iex_is_load, idu_iex_ctrl,
        output iex_idu_ready
    );

endinterface

// File: rtl/u_fwd_mux.sv
// Priority operand bypass for one source: EX over MEM over WB over register-file data.
module u_fwd_mux
    import u_idu_iex_pipe_pkg::*;
(
    input  rf_idx_t src_idx_i,
    input  data_t   rf_data_i,
    input  logic    ex_vld_i,
    input  logic    ex_wen_i,
    input  rf_idx_t ex_rd_idx_i,
    input  data_t   ex_data_i,
    input  logic    mem_vld_i,
    input  logic    mem_wen_i,
    input  rf_idx_t mem_rd_idx_i,
    input  data_t   mem_data_i,
    input  logic    wb_vld_i,
    input  logic    wb_wen_i,
    input  rf_idx_t wb_rd_idx_i,
    input  data_t   wb_data_i,
    output data_t   data_o
);

    always_comb begin
        data_o = rf_data_i;
        if (fwd_hit(ex_vld_i, ex_wen_i, ex_rd_idx_i, src_idx_i)) begin
            data_o = ex_data_i;
        end else if (fwd_hit(mem_vld_i, mem_wen_i, mem_rd_idx_i, src_idx_i)) begin
            data_o = mem_data_i;
        end else if (fwd_hit(wb_vld_i, wb_wen_i, wb_rd_idx_i, src_idx_i)) begin
            data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/u_idu_iex_pipe.sv
// ID/EX pipeline register: captures IDU's decoded slot, resolves bypassing, inserts load-use
// bubbles, kills on BRU redirect and counts stall/flush events.
module u_idu_iex_pipe
    import u_idu_iex_pipe_pkg::*;
#(
    parameter int unsigned CntW = 16
) (
    input  logic            clk,
    input  logic            rst,
    u_idu_iex_pipe_if.slave idu_io,
    input  data_t           alu_iex_cal_data_i,
    input  logic            alu_iex_bru_vld_i,
    input  logic            alu_iex_bru_flush_i,
    input  logic            mem_fwd_vld_i,
    input  logic            mem_fwd_wen_i,
    input  rf_idx_t         mem_fwd_rd_idx_i,
    input  data_t           mem_fwd_data_i,
    input  logic            wb_fwd_vld_i,
    input  logic            wb_fwd_wen_i,
    input  rf_idx_t         wb_fwd_rd_idx_i,
    input  data_t           wb_fwd_data_i,
    output logic            iex_alu_pipe_vld_o,
    output pc_t             iex_alu_pc_o,
    output data_t           iex_alu_rs1_data_o,
    output data_t           iex_alu_rs2_data_o,
    output data_t           iex_alu_imm_data_o,
    output ctrl_t           iex_alu_ctrl_o,
    output rf_idx_t         iex_rd_idx_o,
    output logic            iex_rd_wen_o,
    output logic            iex_is_load_o,
    output logic [CntW-1:0] iex_stall_cnt_o,
    output logic [CntW-1:0] iex_flush_cnt_o
);

    logic      vld_q, vld_d, rd_wen_q, rd_wen_d, is_load_q, is_load_d;
    pc_t       pc_q, pc_d;
    data_t     rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
    ctrl_t     ctrl_q, ctrl_d;
    rf_idx_t   rd_idx_q, rd_idx_d;
    logic [CntW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic  flush, load_use, ex_fwd_vld;
    data_t rs1_fwd, rs2_fwd;

    assign flush    = alu_iex_bru_vld_i & alu_iex_bru_flush_i;
    // Rs compares are unconditional; an unused source only costs a spurious bubble.
    assign load_use = idu_io.idu_iex_vld & vld_q & is_load_q & rd_wen_q & (rd_idx_q != '0) &
                      ((rd_idx_q == idu_io.idu_iex_rs1_idx) |
                       (rd_idx_q == idu_io.idu_iex_rs2_idx));
    assign idu_io.iex_idu_ready = ~load_use | flush;

    // A load's data is not ready in EX; that case is handled by the bubble instead.
    assign ex_fwd_vld = vld_q & ~is_load_q;

    u_fwd_mux u_fwd_rs1 (
        .src_idx_i   (idu_io.idu_iex_rs1_idx),
        .rf_data_i   (idu_io.idu_iex_rs1_data),
        .ex_vld_i    (ex_fwd_vld),
        .ex_wen_i    (rd_wen_q),
        .ex_rd_idx_i (rd_idx_q),
        .ex_data_i   (alu_iex_cal_data_i),
        .mem_vld_i   (mem_fwd_vld_i),
        .mem_wen_i   (mem_fwd_wen_i),
        .mem_rd_idx_i(mem_fwd_rd_idx_i),
        .mem_data_i  (mem_fwd_data_i),
        .wb_vld_i    (wb_fwd_vld_i),
        .wb_wen_i    (wb_fwd_wen_i),
        .wb_rd_idx_i (wb_fwd_rd_idx_i),
        .wb_data_i   (wb_fwd_data_i),
        .data_o      (rs1_fwd)
    );

    u_fwd_mux u_fwd_rs2 (
        .src_idx_i   (idu_io.idu_iex_rs2_idx),
        .rf_data_i   (idu_io.idu_iex_rs2_data),
        .ex_vld_i    (ex_fwd_vld),
        .ex_wen_i    (rd_wen_q),
        .ex_rd_idx_i (rd_idx_q),
        .ex_data_i   (alu_iex_cal_data_i),
        .mem_vld_i   (mem_fwd_vld_i),
        .mem_wen_i   (mem_fwd_wen_i),
        .mem_rd_idx_i(mem_fwd_rd_idx_i),
        .mem_data_i  (mem_fwd_data_i),
        .wb_vld_i    (wb_fwd_vld_i),
        .wb_wen_i    (wb_fwd_wen_i),
        .wb_rd_idx_i (wb_fwd_rd_idx_i),
        .wb_data_i   (wb_fwd_data_i),
        .data_o      (rs2_fwd)
    );

    always_comb begin
        vld_d       = vld_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;
        rd_idx_d    = rd_idx_q;
        rd_wen_d    = rd_wen_q;
        is_load_d   = is_load_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            vld_d  = 1'b0;
            ctrl_d = '0;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CntW'(1);
        end else if (load_use) begin
            vld_d  = 1'b0;
            ctrl_d = '0;
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CntW'(1);
        end else begin
            vld_d     = idu_io.idu_iex_vld;
            pc_d      = idu_io.idu_iex_pc;
            rs1_d     = rs1_fwd;
            rs2_d     = rs2_fwd;
            imm_d     = idu_io.idu_iex_imm_data;
            ctrl_d    = idu_io.idu_iex_vld ? idu_io.idu_iex_ctrl : '0;
            rd_idx_d  = idu_io.idu_iex_rd_idx;
            rd_wen_d  = idu_io.idu_iex_rd_wen;
            is_load_d = idu_io.idu_iex_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= 1'b0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
            rd_idx_q    <= '0;
            rd_wen_q    <= 1'b0;
            is_load_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
            rd_idx_q    <= rd_idx_d;
            rd_wen_q    <= rd_wen_d;
            is_load_q   <= is_load_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign iex_alu_pipe_vld_o = vld_q;
    assign iex_alu_pc_o       = pc_q;
    assign iex_alu_rs1_data_o = rs1_q;
    assign iex_alu_rs2_data_o = rs2_q;
    assign iex_alu_imm_data_o = imm_q;
    assign iex_alu_ctrl_o     = ctrl_q;
    assign iex_rd_idx_o       = rd_idx_q;
    assign iex_rd_wen_o       = rd_wen_q;
    assign iex_is_load_o      = is_load_q;
    assign iex_stall_cnt_o    = stall_cnt_q;
    assign iex_flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_u_idu_iex_pipe.sv
// Bench for the ID/EX register: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a slot-level reference model.
module tb_u_idu_iex_pipe;
    import u_idu_iex_pipe_pkg::*;

    localparam int unsigned CntW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_t   alu_cal;
    logic    bru_vld, bru_flush;
    logic    mem_vld, mem_wen, wb_vld, wb_wen;
    rf_idx_t mem_rd, wb_rd;
    data_t   mem_data, wb_data;

    logic            o_vld, o_rd_wen, o_is_load;
    pc_t             o_pc;
    data_t           o_rs1, o_rs2, o_imm;
    ctrl_t           o_ctrl;
    rf_idx_t         o_rd_idx;
    logic [CntW-1:0] o_stall, o_flush;

    u_idu_iex_pipe_if idu_if ();

    u_idu_iex_pipe #(.CntW(CntW)) dut (
        .clk                (clk),
        .rst                (rst),
        .idu_io             (idu_if),
        .alu_iex_cal_data_i (alu_cal),
        .alu_iex_bru_vld_i  (bru_vld),
        .alu_iex_bru_flush_i(bru_flush),
        .mem_fwd_vld_i      (mem_vld),
        .mem_fwd_wen_i      (mem_wen),
        .mem_fwd_rd_idx_i   (mem_rd),
        .mem_fwd_data_i     (mem_data),
        .wb_fwd_vld_i       (wb_vld),
        .wb_fwd_wen_i       (wb_wen),
        .wb_fwd_rd_idx_i    (wb_rd),
        .wb_fwd_data_i      (wb_data),
        .iex_alu_pipe_vld_o (o_vld),
        .iex_alu_pc_o       (o_pc),
        .iex_alu_rs1_data_o (o_rs1),
        .iex_alu_rs2_data_o (o_rs2),
        .iex_alu_imm_data_o (o_imm),
        .iex_alu_ctrl_o     (o_ctrl),
        .iex_rd_idx_o       (o_rd_idx),
        .iex_rd_wen_o       (o_rd_wen),
        .iex_is_load_o      (o_is_load),
        .iex_stall_cnt_o    (o_stall),
        .iex_flush_cnt_o    (o_flush)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the instruction slot as a record plus plain event tallies.
    typedef struct {
        bit      vld;
        pc_t     pc;
        data_t   rs1, rs2, imm;
        ctrl_t   ctrl;
        rf_idx_t rd;
        bit      wen, load;
    } slot_t;

    slot_t m;
    int    n_stall_ev, n_flush_ev;

    function automatic logic [CntW-1:0] sat(input int n);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    function automatic bit m_load_use();
        return idu_if.idu_iex_vld && m.vld && m.load && m.wen && m.rd != 0 &&
               (m.rd == idu_if.idu_iex_rs1_idx || m.rd == idu_if.idu_iex_rs2_idx);
    endfunction

    function automatic bit m_ready();
        return !m_load_use() || (bru_vld && bru_flush);
    endfunction

    function automatic data_t m_operand(input rf_idx_t idx, input data_t rf);
        if (idx == 0) return rf;
        if (m.vld && !m.load && m.wen && m.rd == idx) return alu_cal;
        if (mem_vld && mem_wen && mem_rd == idx) return mem_data;
        if (wb_vld && wb_wen && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m = '{default: 0};
            n_stall_ev = 0;
            n_flush_ev = 0;
        end else if (bru_vld && bru_flush) begin
            m.vld = 0;
            m.ctrl = '0;
            n_flush_ev++;
        end else if (m_load_use()) begin
            m.vld = 0;
            m.ctrl = '0;
            n_stall_ev++;
        end else begin
            slot_t nx;
            nx.rs1  = m_operand(idu_if.idu_iex_rs1_idx, idu_if.idu_iex_rs1_data);
            nx.rs2  = m_operand(idu_if.idu_iex_rs2_idx, idu_if.idu_iex_rs2_data);
            nx.vld  = idu_if.idu_iex_vld;
            nx.pc   = idu_if.idu_iex_pc;
            nx.imm  = idu_if.idu_iex_imm_data;
            nx.ctrl = idu_if.idu_iex_vld ? idu_if.idu_iex_ctrl : '0;
            nx.rd   = idu_if.idu_iex_rd_idx;
            nx.wen  = idu_if.idu_iex_rd_wen;
            nx.load = idu_if.idu_iex_is_load;
            m = nx;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 64'(idu_if.iex_idu_ready), 64'(m_ready()));
            check("pipe_vld", 64'(o_vld), 64'(m.vld));
            check("ctrl", 64'(o_ctrl), 64'(m.ctrl));
            check("stall_cnt", 64'(o_stall), 64'(sat(n_stall_ev)));
            check("flush_cnt", 64'(o_flush), 64'(sat(n_flush_ev)));
            if (m.vld) begin
                check("pc", 64'(o_pc), 64'(m.pc));
                check("rs1_data", 64'(o_rs1), 64'(m.rs1));
                check("rs2_data", 64'(o_rs2), 64'(m.rs2));
                check("imm_data", 64'(o_imm), 64'(m.imm));
                check("rd_idx", 64'(o_rd_idx), 64'(m.rd));
                check("rd_wen", 64'(o_rd_wen), 64'(m.wen));
                check("is_load", 64'(o_is_load), 64'(m.load));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        idu_if.idu_iex_vld      = 0;
        idu_if.idu_iex_pc       = '0;
        idu_if.idu_iex_rs1_idx  = '0;
        idu_if.idu_iex_rs2_idx  = '0;
        idu_if.idu_iex_rs1_data = '0;
        idu_if.idu_iex_rs2_data = '0;
        idu_if.idu_iex_imm_data = '0;
        idu_if.idu_iex_rd_idx   = '0;
        idu_if.idu_iex_rd_wen   = 0;
        idu_if.idu_iex_is_load  = 0;
        idu_if.idu_iex_ctrl     = '0;
        alu_cal = '0;
        bru_vld = 0;
        bru_flush = 0;
        mem_vld = 0;
        mem_wen = 0;
        mem_rd = '0;
        mem_data = '0;
        wb_vld = 0;
        wb_wen = 0;
        wb_rd = '0;
        wb_data = '0;
    endtask

    task automatic instr(input rf_idx_t rs1, input rf_idx_t rs2, input rf_idx_t rd,
                         input bit wen, input bit load);
        idu_if.idu_iex_vld     = 1;
        idu_if.idu_iex_rs1_idx = rs1;
        idu_if.idu_iex_rs2_idx = rs2;
        idu_if.idu_iex_rd_idx  = rd;
        idu_if.idu_iex_rd_wen  = wen;
        idu_if.idu_iex_is_load = load;
    endtask

    ctrl_t sub_ctrl;

    initial begin
        sub_ctrl = (ctrl_t'(1) << CtrlAdderVld) | (ctrl_t'(1) << CtrlAdderSub);
        rst = 1;
        idle();
        cyc();
        cyc();
        chk_en = 1;
        rst = 0;

        // Mid-stream reset after a flush and a captured load.
        bru_vld = 1;
        bru_flush = 1;
        cyc();
        idle();
        instr(5'd1, 5'd2, 5'd1, 1, 1);
        idu_if.idu_iex_ctrl = 18'h3FFFF;
        cyc();
        check("pre_rst_vld", 64'(o_vld), 64'd1);
        check("pre_rst_flush_cnt", 64'(o_flush), 64'd1);
        rst = 1;
        cyc();
        check("rst_vld", 64'(o_vld), 64'd0);
        check("rst_ctrl", 64'(o_ctrl), 64'd0);
        check("rst_stall_cnt", 64'(o_stall), 64'd0);
        check("rst_flush_cnt", 64'(o_flush), 64'd0);
        rst = 0;
        idle();
        #1 check("rst_ready", 64'(idu_if.iex_idu_ready), 64'd1);

        // EX forward: ADD x5 then ADD x6,x5,x5 with stale RF data.
        instr(5'd1, 5'd2, 5'd5, 1, 0);
        idu_if.idu_iex_ctrl = ctrl_t'(1) << CtrlAdderVld;
        cyc();
        instr(5'd5, 5'd5, 5'd6, 1, 0);
        idu_if.idu_iex_rs1_data = 32'hDEAD;
        idu_if.idu_iex_rs2_data = 32'hDEAD;
        alu_cal = 32'h10;
        cyc();
        check("ex_fwd_rs1", 64'(o_rs1), 64'h10);
        check("ex_fwd_rs2", 64'(o_rs2), 64'h10);

        // Load-use: LW x7, then SUB x8,x7,x1 stalls one cycle and takes the MEM forward.
        idle();
        instr(5'd0, 5'd0, 5'd7, 1, 1);
        cyc();
        idle();
        instr(5'd7, 5'd1, 5'd8, 1, 0);
        idu_if.idu_iex_rs2_data = 32'h55;
        idu_if.idu_iex_ctrl = sub_ctrl;
        #1 check("lu_ready", 64'(idu_if.iex_idu_ready), 64'd0);
        cyc();
        check("lu_bubble_vld", 64'(o_vld), 64'd0);
        check("lu_bubble_ctrl", 64'(o_ctrl), 64'd0);
        check("lu_stall_cnt", 64'(o_stall), 64'd1);
        mem_vld = 1;
        mem_wen = 1;
        mem_rd = 5'd7;
        mem_data = 32'h1234;
        #1 check("lu_release_ready", 64'(idu_if.iex_idu_ready), 64'd1);
        cyc();
        check("lu_vld", 64'(o_vld), 64'd1);
        check("lu_mem_fwd_rs1", 64'(o_rs1), 64'h1234);
        check("lu_rf_rs2", 64'(o_rs2), 64'h55);
        check("lu_ctrl", 64'(o_ctrl), 64'(sub_ctrl));

        // MEM beats WB; WB alone wins over the RF.
        idle();
        instr(5'd3, 5'd3, 5'd9, 0, 0);
        mem_vld = 1; mem_wen = 1; mem_rd = 5'd3; mem_data = 32'hA;
        wb_vld = 1;  wb_wen = 1;  wb_rd = 5'd3;  wb_data = 32'hB;
        cyc();
        check("mem_over_wb", 64'(o_rs1), 64'hA);
        mem_vld = 0;
        instr(5'd3, 5'd3, 5'd0, 1, 0);
        cyc();
        check("wb_only", 64'(o_rs2), 64'hB);

        // x0 never forwards, even with every stage claiming rd=0.
        idle();
        instr(5'd0, 5'd0, 5'd2, 0, 0);
        alu_cal = 32'hFF;
        mem_vld = 1; mem_wen = 1; mem_data = 32'hFF;
        wb_vld = 1;  wb_wen = 1;  wb_data = 32'hFF;
        cyc();
        check("x0_rs1", 64'(o_rs1), 64'd0);
        check("x0_rs2", 64'(o_rs2), 64'd0);

        // Flush while load-use is pending: flush wins, only flush_cnt moves.
        idle();
        instr(5'd0, 5'd0, 5'd9, 1, 1);
        cyc();
        idle();
        instr(5'd9, 5'd0, 5'd10, 1, 0);
        bru_vld = 1;
        bru_flush = 1;
        #1 check("flush_lu_ready", 64'(idu_if.iex_idu_ready), 64'd1);
        cyc();
        check("flush_lu_vld", 64'(o_vld), 64'd0);
        check("flush_lu_flush_cnt", 64'(o_flush), 64'd1);
        check("flush_lu_stall_cnt", 64'(o_stall), 64'd1);

        // Randomized traffic; small index range keeps hazards frequent.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            idu_if.idu_iex_vld      = ($urandom_range(0, 3) != 0);
            idu_if.idu_iex_pc       = $urandom;
            idu_if.idu_iex_rs1_idx  = rf_idx_t'($urandom_range(0, 3));
            idu_if.idu_iex_rs2_idx  = rf_idx_t'($urandom_range(0, 3));
            idu_if.idu_iex_rs1_data = $urandom;
            idu_if.idu_iex_rs2_data = $urandom;
            idu_if.idu_iex_imm_data = $urandom;
            idu_if.idu_iex_rd_idx   = rf_idx_t'($urandom_range(0, 3));
            idu_if.idu_iex_rd_wen   = ($urandom_range(0, 9) < 7);
            idu_if.idu_iex_is_load  = ($urandom_range(0, 9) < 3);
            idu_if.idu_iex_ctrl     = ctrl_t'($urandom);
            alu_cal   = $urandom;
            bru_vld   = ($urandom_range(0, 3) == 0);
            bru_flush = $urandom_range(0, 1) == 1;
            mem_vld   = $urandom_range(0, 1) == 1;
            mem_wen   = $urandom_range(0, 1) == 1;
            mem_rd    = rf_idx_t'($urandom_range(0, 3));
            mem_data  = $urandom;
            wb_vld    = $urandom_range(0, 1) == 1;
            wb_wen    = $urandom_range(0, 1) == 1;
            wb_rd     = rf_idx_t'($urandom_range(0, 3));
            wb_data   = $urandom;
            cyc();
        end
        rst = 0;

        // Flush counter saturation.
        idle();
        bru_vld = 1;
        bru_flush = 1;
        for (int i = 0; i < 65536 + 5; i++) cyc();
        check("flush_cnt_sat", 64'(o_flush), 64'hFFFF);
        idle();
        cyc();
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/u_idu_iex_pipe.md
Name: u_idu_iex_pipe

Overview:
- ID/EX pipeline register directly upstream of the IEX ALU.
- Captures the decoded instruction from IDU: PC, operands, immediate, rd info and the 18-bit ALU control bundle.
- Resolves operand bypassing from EX/MEM/WB and inserts a load-use bubble.
- Kills the captured slot on BRU redirect.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- CTRL_W, 18, width of ALU control flag bundle (bit order fixed in package)
- RF_IDX_W, 5, register index width
- CNT_W, 16, perf counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- idu_iex_vld  in  1  IDU holds a valid decoded instruction
- idu_iex_pc  in  `PC_WIDTH  instruction PC
- idu_iex_rs1_idx / idu_iex_rs2_idx  in  RF_IDX_W  source indices
- idu_iex_rs1_data / idu_iex_rs2_data  in  `DATA_WIDTH  register-file read data
- idu_iex_imm_data  in  `DATA_WIDTH  immediate
- idu_iex_rd_idx  in  RF_IDX_W  destination index
- idu_iex_rd_wen  in  1  writes rd
- idu_iex_is_load  in  1  load instruction
- idu_iex_ctrl  in  CTRL_W  ALU control flags
- iex_idu_ready  out  1  IDU may advance (0 = load-use stall)
- alu_iex_cal_data  in  `DATA_WIDTH  combinational ALU result of the instruction in this register
- alu_iex_bru_vld / alu_iex_bru_flush  in  1  BRU redirect qualifiers
- mem_fwd_vld, mem_fwd_wen  in  1  MEM-stage instruction valid / writes rd
- mem_fwd_rd_idx  in  RF_IDX_W  MEM-stage rd
- mem_fwd_data  in  `DATA_WIDTH  MEM-stage writeback value
- wb_fwd_vld, wb_fwd_wen, wb_fwd_rd_idx, wb_fwd_data  in  same as MEM, WB stage
- iex_alu_pipe_vld  out  1  slot valid
- iex_alu_pc, iex_alu_rs1_data, iex_alu_rs2_data, iex_alu_imm_data  out  registered to ALU
- iex_alu_ctrl  out  CTRL_W  registered flags, fanned to the iex_alu_flag_* inputs
- iex_rd_idx, iex_rd_wen, iex_is_load  out  carried to MEM
- iex_stall_cnt, iex_flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset: all outputs and registers to 0.
  - pipe_vld=0, ctrl=0, counters=0.
  - iex_idu_ready=1 combinationally once rst deasserts.
- flush = alu_iex_bru_vld & alu_iex_bru_flush.
- load_use = idu_iex_vld & iex_alu_pipe_vld & iex_is_load & iex_rd_wen & (iex_rd_idx!=0) & (iex_rd_idx==rs1_idx | iex_rd_idx==rs2_idx).
  - Compared unconditionally; unused rs compares cause a harmless conservative stall.
- iex_idu_ready = ~load_use | flush.
- Per-cycle priority, registered at posedge: rst > flush > load_use > capture.
  - flush: pipe_vld<=0; IDU instruction dropped. IDU is also being killed; ready=1 lets it advance. flush_cnt++.
  - load_use: pipe_vld<=0 (bubble), other fields don't-care (ctrl<=0 required); IDU holds. stall_cnt++.
  - capture: pipe_vld<=idu_iex_vld. When idu_iex_vld=0, ctrl<=0.
- Bypass per source at capture, priority EX > MEM > WB > RF. Applies only when idx!=0 and the source's vld & wen & rd match.
  - EX source = alu_iex_cal_data, used when iex_alu_pipe_vld & ~iex_is_load. The load case is covered by load_use.
  - idx 0 always yields RF data; no forward.
- Latency: 1 cycle IDU→ALU; a load-use stall costs exactly 1 bubble. Next cycle the load is in MEM and the MEM forward supplies the data.
- Counters saturate at all-ones; no wrap.
- Simultaneous flush and load_use: flush wins, only flush_cnt increments.

Decomposition:
- Shared package/defines:
  - CTRL bit positions (adder_sel_src1_pc, adder_sel_src2_rs2, general_sel_src2_rs2, unsigned, adder_vld, adder_sub, comparator_vld, and, or, xor, right_shift, logical_shift, jal, jalr, bge, blt, beq, bne: bit 0..17)
  - RF_IDX_W; reuse `PC_WIDTH/`DATA_WIDTH.
- One sub-module u_fwd_mux: 3-source priority bypass for one operand, instantiated twice (rs1, rs2).

Test Plan:
- Reset mid-stream: rst=1 with pipe_vld=1 → next cycle pipe_vld=0, ctrl=0, counters=0.
- ADD x5 (EX result 0x10) followed by ADD x6,x5,x5 → captured rs1=rs2=0x10 regardless of RF value 0xDEAD.
- LW x7 in EX, IDU SUB x8,x7,x1 → ready=0, one bubble, stall_cnt=1. Next cycle mem_fwd x7=0x1234 → rs1=0x1234.
- MEM rd=x3 data 0xA, WB rd=x3 data 0xB, IDU reads x3 → 0xA (MEM wins). With only WB matching → 0xB.
- x0 source with EX rd=0, wen=1, data 0xFF → operand equals RF data 0.
- BRU flush while load_use is asserted → pipe_vld=0, ready=1, flush_cnt+1, stall_cnt unchanged. 2^16+5 flushes → flush_cnt=0xFFFF.
